csplit2_6b_cache: RTL and testbench

- Clocked 1-to-2 split (demux): the counterpart of the 2-to-1 arbitrated merge used in the cache control path.
- Accepts one drive/free token with data on a single input channel.
- Routes the token to output channel 0 or 1 according to a select bit.
- Returns the input free once the token is safely buffered. Each output runs its own drive/free handshake with a per-output FIFO.

---
 rtl/csplit2_6b_cache_pkg.sv | 10 +
 rtl/csplit2_6b_cache_fifo.sv | 72 +++++++
 rtl/csplit2_6b_cache.sv | 170 +++++++++++++++++
 tb/tb_csplit2_6b_cache.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csplit2_6b_cache_pkg.sv
// Shared types for the 1-to-2 split: handshake state of each output channel.
package csplit2_6b_cache_pkg;

    // IDLE: no token outstanding downstream; BUSY: a launched token awaits its free pulse.
    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } chanState_e;

endpackage

// File: rtl/csplit2_6b_cache_fifo.sv
// Small synchronous FIFO buffering tokens in front of one output channel.
module csplit_fifo #(
    parameter int DATA_WIDTH = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  pushOk;
    logic                  popOk;

    // Flags come from the registered count, so a same-cycle pop never makes room for a push.
    assign full   = (count_q == DEPTH_CNT);
    assign empty  = (count_q == '0);
    assign head   = mem_q[rdPtr_q];
    assign pushOk = push && !full;
    assign popOk  = pop && !empty;

    // Advance pointers (wrapping at the power-of-two depth) and track occupancy.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushOk) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popOk) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (pushOk && !popOk) begin
            count_d = count_q + CNT_W'(1);
        end else if (popOk && !pushOk) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= wdata;
        end
    end

endmodule

// File: rtl/csplit2_6b_cache.sv
// Clocked 1-to-2 split: one drive/free input routed by a select bit into two buffered outputs.
module csplit2_6b_cache
    import csplit2_6b_cache_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_drive,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_sel,
    output logic                  o_free,
    output logic                  o_drive0,
    output logic                  o_drive1,
    output logic [DATA_WIDTH-1:0] o_data0,
    output logic [DATA_WIDTH-1:0] o_data1,
    input  logic                  i_free0,
    input  logic                  i_free1,
    output logic                  o_err
);

    logic                  holdValid_q, holdValid_d;
    logic                  holdSel_q, holdSel_d;
    logic [DATA_WIDTH-1:0] holdData_q, holdData_d;
    logic                  free_q, free_d;
    logic                  err_q, err_d;
    logic                  accept;

    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            full;
    logic [1:0]            empty;
    logic [1:0]            freeIn;
    logic [DATA_WIDTH-1:0] head [2];

    chanState_e            state_q [2];
    chanState_e            state_d [2];
    logic [1:0]            drive_q, drive_d;
    logic [DATA_WIDTH-1:0] data_q [2];
    logic [DATA_WIDTH-1:0] data_d [2];

    assign freeIn   = {i_free1, i_free0};
    assign push     = {accept & holdSel_q, accept & ~holdSel_q};
    assign o_free   = free_q;
    assign o_err    = err_q;
    assign o_drive0 = drive_q[0];
    assign o_drive1 = drive_q[1];
    assign o_data0  = data_q[0];
    assign o_data1  = data_q[1];

    csplit_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo0 (
        .clk  (clk),
        .rstn (rstn),
        .push (push[0]),
        .wdata(holdData_q),
        .pop  (pop[0]),
        .full (full[0]),
        .empty(empty[0]),
        .head (head[0])
    );

    csplit_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo1 (
        .clk  (clk),
        .rstn (rstn),
        .push (push[1]),
        .wdata(holdData_q),
        .pop  (pop[1]),
        .full (full[1]),
        .empty(empty[1]),
        .head (head[1])
    );

    // Input stage: capture into the single holding register, hand off to the selected FIFO, flag misuse.
    always_comb begin
        holdValid_d = holdValid_q;
        holdSel_d   = holdSel_q;
        holdData_d  = holdData_q;
        free_d      = 1'b0;
        err_d       = err_q;
        accept      = 1'b0;
        if (holdValid_q) begin
            if (!full[holdSel_q]) begin
                accept      = 1'b1;
                holdValid_d = 1'b0;
                free_d      = 1'b1;
            end
            if (i_drive) begin
                err_d = 1'b1;
            end
        end else if (i_drive) begin
            holdValid_d = 1'b1;
            holdSel_d   = i_sel;
            holdData_d  = i_data;
        end
        if (i_free0 && (state_q[0] == CH_IDLE)) begin
            err_d = 1'b1;
        end
        if (i_free1 && (state_q[1] == CH_IDLE)) begin
            err_d = 1'b1;
        end
    end

    // Input-stage registers; reset discards any held token and clears the sticky error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            holdValid_q <= 1'b0;
            holdSel_q   <= 1'b0;
            holdData_q  <= '0;
            free_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            holdValid_q <= holdValid_d;
            holdSel_q   <= holdSel_d;
            holdData_q  <= holdData_d;
            free_q      <= free_d;
            err_q       <= err_d;
        end
    end

    // Output channels: an idle channel launches its FIFO head, a busy one waits for the free pulse.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            state_d[n] = state_q[n];
            data_d[n]  = data_q[n];
            drive_d[n] = 1'b0;
            pop[n]     = 1'b0;
            case (state_q[n])
                CH_IDLE: begin
                    if (!empty[n]) begin
                        pop[n]     = 1'b1;
                        data_d[n]  = head[n];
                        drive_d[n] = 1'b1;
                        state_d[n] = CH_BUSY;
                    end
                end
                CH_BUSY: begin
                    if (freeIn[n]) begin
                        state_d[n] = CH_IDLE;
                    end
                end
                default: state_d[n] = CH_IDLE;
            endcase
        end
    end

    // Output channel registers; launched data stays on the port until the next launch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q[0] <= CH_IDLE;
            state_q[1] <= CH_IDLE;
            data_q[0]  <= '0;
            data_q[1]  <= '0;
            drive_q    <= '0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            data_q[0]  <= data_d[0];
            data_q[1]  <= data_d[1];
            drive_q    <= drive_d;
        end
    end

endmodule

// File: tb/tb_csplit2_6b_cache.sv
// Self-checking bench for csplit2_6b_cache: directed scenarios plus a randomized ordering scoreboard.
module tb_csplit2_6b_cache;

    localparam int DW = 6;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_drive;
    logic [DW-1:0] i_data;
    logic          i_sel;
    logic          o_free;
    logic          o_drive0;
    logic          o_drive1;
    logic [DW-1:0] o_data0;
    logic [DW-1:0] o_data1;
    logic          i_free0;
    logic          i_free1;
    logic          o_err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] rx0 [$];
    logic [DW-1:0] rx1 [$];
    int freeCnt = 0;

    bit autoFree0, autoFree1;
    bit armed0, armed1;
    int wait0, wait1;

    csplit2_6b_cache #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_drive (i_drive),
        .i_data  (i_data),
        .i_sel   (i_sel),
        .o_free  (o_free),
        .o_drive0(o_drive0),
        .o_drive1(o_drive1),
        .o_data0 (o_data0),
        .o_data1 (o_data1),
        .i_free0 (i_free0),
        .i_free1 (i_free1),
        .o_err   (o_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Record every launched token and every free pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (o_drive0 === 1'b1) rx0.push_back(o_data0);
        if (o_drive1 === 1'b1) rx1.push_back(o_data1);
        if (o_free === 1'b1) freeCnt++;
    end

    // Downstream model: after a launch, answer with a free pulse after a random delay.
    task automatic service();
        i_free0 = 1'b0;
        i_free1 = 1'b0;
        if (autoFree0 && o_drive0) begin armed0 = 1; wait0 = $urandom_range(0, 3); end
        if (autoFree1 && o_drive1) begin armed1 = 1; wait1 = $urandom_range(0, 3); end
        if (armed0) begin
            if (wait0 == 0) begin i_free0 = 1'b1; armed0 = 0; end else wait0--;
        end
        if (armed1) begin
            if (wait1 == 0) begin i_free1 = 1'b1; armed1 = 0; end else wait1--;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        service();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic waitFree(output bit ok);
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            if (o_free === 1'b1) begin
                ok = 1;
                return;
            end
            step();
        end
    endtask

    // Drive one token, wait for its free, and return in the earliest cycle a new drive is legal.
    task automatic sendToken(input logic [DW-1:0] d, input logic s, output bit ok);
        i_drive = 1'b1;
        i_data  = d;
        i_sel   = s;
        step();
        i_drive = 1'b0;
        waitFree(ok);
        step();
    endtask

    task automatic freePulse(input int ch);
        if (ch == 0) i_free0 = 1'b1; else i_free1 = 1'b1;
        step();
    endtask

    task automatic doReset();
        autoFree0 = 0; autoFree1 = 0; armed0 = 0; armed1 = 0;
        i_drive = 1'b0; i_free0 = 1'b0; i_free1 = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        i_drive = 1'b0; i_data = '0; i_sel = 1'b0; i_free0 = 1'b0; i_free1 = 1'b0;
        rstn = 1'b0;
        #3;
        checks++; if (o_free !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_free: got %b expected 0", o_free); end
        checks++; if (o_drive0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_drive0: got %b expected 0", o_drive0); end
        checks++; if (o_drive1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_drive1: got %b expected 0", o_drive1); end
        checks++; if (o_data0 !== 6'h00) begin errors++; $display("[TB] FAIL reset_o_data0: got %h expected 00", o_data0); end
        checks++; if (o_data1 !== 6'h00) begin errors++; $display("[TB] FAIL reset_o_data1: got %h expected 00", o_data1); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_err: got %b expected 0", o_err); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step();
    endtask

    task automatic test_single();
        int b0, b1;
        b0 = rx0.size();
        b1 = rx1.size();
        i_drive = 1'b1; i_data = 6'h2A; i_sel = 1'b0;
        step();
        i_drive = 1'b0;
        checks++; if (o_free !== 1'b0) begin errors++; $display("[TB] FAIL single_free_c1: got %b expected 0", o_free); end
        step();
        checks++; if (o_free !== 1'b1) begin errors++; $display("[TB] FAIL single_free_c2: got %b expected 1", o_free); end
        checks++; if (o_drive0 !== 1'b0) begin errors++; $display("[TB] FAIL single_drive_c2: got %b expected 0", o_drive0); end
        step();
        checks++; if (o_drive0 !== 1'b1 || o_data0 !== 6'h2A) begin errors++; $display("[TB] FAIL single_drive_c3: got drive=%b data=%h expected drive=1 data=2a", o_drive0, o_data0); end
        checks++; if (o_free !== 1'b0) begin errors++; $display("[TB] FAIL single_free_c3: got %b expected 0", o_free); end
        step();
        checks++; if (o_drive0 !== 1'b0 || o_data0 !== 6'h2A) begin errors++; $display("[TB] FAIL single_hold_c4: got drive=%b data=%h expected drive=0 data=2a", o_drive0, o_data0); end
        freePulse(0);
        checks++; if (o_err !== 1'b0) begin errors++; $display("[TB] FAIL single_err: got %b expected 0", o_err); end
        // A second token only launches on time if the free returned the channel to idle.
        i_drive = 1'b1; i_data = 6'h0C; i_sel = 1'b0;
        step();
        i_drive = 1'b0;
        steps(2);
        checks++; if (o_drive0 !== 1'b1 || o_data0 !== 6'h0C) begin errors++; $display("[TB] FAIL single_relaunch: got drive=%b data=%h expected drive=1 data=0c", o_drive0, o_data0); end
        step();
        freePulse(0);
        steps(2);
        checks++; if (rx1.size() !== b1) begin errors++; $display("[TB] FAIL single_no_ch1: got %0d launches expected %0d", rx1.size() - b1, 0); end
        checks++; if (rx0.size() !== b0 + 2) begin errors++; $display("[TB] FAIL single_ch0_count: got %0d expected 2", rx0.size() - b0); end
    endtask

    task automatic test_alternate();
        int b0, b1, bf;
        bit ok;
        doReset();
        b0 = rx0.size(); b1 = rx1.size(); bf = freeCnt;
        autoFree0 = 1; autoFree1 = 1;
        sendToken(6'h01, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL alt_free_01: got timeout expected o_free"); end
        sendToken(6'h02, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL alt_free_02: got timeout expected o_free"); end
        sendToken(6'h03, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL alt_free_03: got timeout expected o_free"); end
        steps(20);
        checks++; if (rx1.size() !== b1 + 2 || rx0.size() !== b0 + 1) begin
            errors++; $display("[TB] FAIL alt_counts: got ch0=%0d ch1=%0d expected ch0=1 ch1=2", rx0.size() - b0, rx1.size() - b1);
        end else begin
            checks++; if (rx1[b1] !== 6'h01 || rx1[b1+1] !== 6'h03) begin errors++; $display("[TB] FAIL alt_ch1_order: got %h,%h expected 01,03", rx1[b1], rx1[b1+1]); end
            checks++; if (rx0[b0] !== 6'h02) begin errors++; $display("[TB] FAIL alt_ch0_data: got %h expected 02", rx0[b0]); end
        end
        checks++; if (freeCnt - bf !== 3) begin errors++; $display("[TB] FAIL alt_free_count: got %0d expected 3", freeCnt - bf); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("[TB] FAIL alt_err: got %b expected 0", o_err); end
    endtask

    task automatic test_backpressure();
        int b0, bf;
        bit ok;
        logic [DW-1:0] expSeq [4];
        expSeq[0] = 6'h10; expSeq[1] = 6'h11; expSeq[2] = 6'h12; expSeq[3] = 6'h13;
        doReset();
        b0 = rx0.size();
        for (int i = 0; i < 3; i++) begin
            sendToken(expSeq[i], 1'b0, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_fill_%0d: got timeout expected o_free", i); end
        end
        bf = freeCnt;
        i_drive = 1'b1; i_data = expSeq[3]; i_sel = 1'b0;
        step();
        i_drive = 1'b0;
        steps(10);
        checks++; if (freeCnt !== bf) begin errors++; $display("[TB] FAIL bp_free_withheld: got %0d frees expected 0", freeCnt - bf); end
        checks++; if (rx0.size() !== b0 + 1) begin errors++; $display("[TB] FAIL bp_one_launch: got %0d expected 1", rx0.size() - b0); end
        freePulse(0);
        checks++; if (o_drive0 !== 1'b0 || o_free !== 1'b0) begin errors++; $display("[TB] FAIL bp_after_free_c1: got drive=%b free=%b expected 0,0", o_drive0, o_free); end
        step();
        checks++; if (o_drive0 !== 1'b1 || o_data0 !== 6'h11 || o_free !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_relaunch_c2: got drive=%b data=%h free=%b expected 1,11,0", o_drive0, o_data0, o_free);
        end
        step();
        checks++; if (o_free !== 1'b1) begin errors++; $display("[TB] FAIL bp_held_free_c3: got %b expected 1", o_free); end
        for (int i = 0; i < 3; i++) begin
            steps(2);
            freePulse(0);
        end
        steps(4);
        checks++; if (rx0.size() !== b0 + 4) begin
            errors++; $display("[TB] FAIL bp_total: got %0d expected 4", rx0.size() - b0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (rx0[b0+i] !== expSeq[i]) begin errors++; $display("[TB] FAIL bp_order_%0d: got %h expected %h", i, rx0[b0+i], expSeq[i]); end
            end
        end
        checks++; if (o_err !== 1'b0) begin errors++; $display("[TB] FAIL bp_err: got %b expected 0", o_err); end
    endtask

    task automatic test_independence();
        int b0, b1, bf;
        bit ok;
        doReset();
        b0 = rx0.size(); b1 = rx1.size();
        for (int i = 0; i < 3; i++) begin
            sendToken(6'(32 + i), 1'b0, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL ind_fill_%0d: got timeout expected o_free", i); end
        end
        bf = freeCnt;
        i_drive = 1'b1; i_data = 6'h23; i_sel = 1'b0;
        step();
        i_drive = 1'b0;
        steps(8);
        checks++; if (freeCnt !== bf || rx1.size() !== b1) begin
            errors++; $display("[TB] FAIL ind_blocked: got frees=%0d ch1=%0d expected 0,0", freeCnt - bf, rx1.size() - b1);
        end
        freePulse(0);
        waitFree(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL ind_recover_free: got timeout expected o_free"); end
        step();
        sendToken(6'h15, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL ind_ch1_free: got timeout expected o_free"); end
        steps(2);
        checks++; if (rx1.size() !== b1 + 1) begin
            errors++; $display("[TB] FAIL ind_ch1_launch: got %0d expected 1", rx1.size() - b1);
        end else begin
            checks++; if (rx1[b1] !== 6'h15) begin errors++; $display("[TB] FAIL ind_ch1_data: got %h expected 15", rx1[b1]); end
        end
        for (int i = 0; i < 3; i++) begin
            steps(2);
            freePulse(0);
        end
        steps(4);
        checks++; if (rx0.size() !== b0 + 4) begin
            errors++; $display("[TB] FAIL ind_ch0_total: got %0d expected 4", rx0.size() - b0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (rx0[b0+i] !== 6'(32 + i)) begin errors++; $display("[TB] FAIL ind_ch0_order_%0d: got %h expected %h", i, rx0[b0+i], 6'(32 + i)); end
            end
        end
        checks++; if (o_err !== 1'b0) begin errors++; $display("[TB] FAIL ind_err: got %b expected 0", o_err); end
    endtask

    task automatic test_errors();
        int b0, b1, bf;
        bit ok;
        doReset();
        b0 = rx0.size(); bf = freeCnt;
        i_drive = 1'b1; i_data = 6'h2B; i_sel = 1'b0;
        step();
        i_data = 6'h3C;
        step();
        i_drive = 1'b0;
        checks++; if (o_err !== 1'b1) begin errors++; $display("[TB] FAIL err_double_drive: got %b expected 1", o_err); end
        steps(8);
        checks++; if (freeCnt - bf !== 1) begin errors++; $display("[TB] FAIL err_drop_frees: got %0d expected 1", freeCnt - bf); end
        checks++; if (rx0.size() !== b0 + 1) begin
            errors++; $display("[TB] FAIL err_drop_launches: got %0d expected 1", rx0.size() - b0);
        end else begin
            checks++; if (rx0[b0] !== 6'h2B) begin errors++; $display("[TB] FAIL err_kept_token: got %h expected 2b", rx0[b0]); end
        end
        doReset();
        checks++; if (o_err !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared: got %b expected 0", o_err); end
        b1 = rx1.size();
        freePulse(1);
        checks++; if (o_err !== 1'b1) begin errors++; $display("[TB] FAIL err_idle_free: got %b expected 1", o_err); end
        i_drive = 1'b1; i_data = 6'h2D; i_sel = 1'b1;
        step();
        i_drive = 1'b0;
        steps(2);
        checks++; if (o_drive1 !== 1'b1 || o_data1 !== 6'h2D) begin
            errors++; $display("[TB] FAIL err_state_kept: got drive=%b data=%h expected 1,2d", o_drive1, o_data1);
        end
        steps(5);
        checks++; if (o_err !== 1'b1 || rx1.size() !== b1 + 1) begin
            errors++; $display("[TB] FAIL err_sticky: got err=%b launches=%0d expected 1,1", o_err, rx1.size() - b1);
        end
    endtask

    task automatic test_midreset();
        int b0, b1, bf;
        bit ok;
        doReset();
        for (int i = 0; i < 3; i++) begin
            sendToken(6'(48 + i), 1'b0, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL mr_fill_%0d: got timeout expected o_free", i); end
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (o_free !== 1'b0 || o_drive0 !== 1'b0 || o_drive1 !== 1'b0 || o_err !== 1'b0) begin
            errors++; $display("[TB] FAIL mr_pulses: got free=%b d0=%b d1=%b err=%b expected all 0", o_free, o_drive0, o_drive1, o_err);
        end
        checks++; if (o_data0 !== 6'h00 || o_data1 !== 6'h00) begin
            errors++; $display("[TB] FAIL mr_data: got %h,%h expected 00,00", o_data0, o_data1);
        end
        b0 = rx0.size(); b1 = rx1.size(); bf = freeCnt;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        steps(10);
        checks++; if (rx0.size() !== b0 || rx1.size() !== b1 || freeCnt !== bf) begin
            errors++; $display("[TB] FAIL mr_spurious: got d0=%0d d1=%0d free=%0d expected 0,0,0", rx0.size() - b0, rx1.size() - b1, freeCnt - bf);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp0 [$];
        logic [DW-1:0] exp1 [$];
        logic [DW-1:0] d;
        logic s;
        int b0, b1, bf, n;
        bit ok;
        doReset();
        b0 = rx0.size(); b1 = rx1.size(); bf = freeCnt;
        autoFree0 = 1; autoFree1 = 1;
        n = 40;
        for (int i = 0; i < n; i++) begin
            d = DW'($urandom_range(0, 63));
            s = 1'($urandom_range(0, 1));
            if (s) exp1.push_back(d); else exp0.push_back(d);
            sendToken(d, s, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL rnd_free_%0d: got timeout expected o_free", i); end
            steps($urandom_range(0, 2));
        end
        for (int k = 0; k < 300; k++) begin
            if (rx0.size() - b0 >= exp0.size() && rx1.size() - b1 >= exp1.size()) break;
            step();
        end
        checks++; if (rx0.size() - b0 !== exp0.size() || rx1.size() - b1 !== exp1.size()) begin
            errors++; $display("[TB] FAIL rnd_counts: got ch0=%0d ch1=%0d expected ch0=%0d ch1=%0d", rx0.size() - b0, rx1.size() - b1, exp0.size(), exp1.size());
        end else begin
            for (int i = 0; i < exp0.size(); i++) begin
                checks++; if (rx0[b0+i] !== exp0[i]) begin errors++; $display("[TB] FAIL rnd_ch0_%0d: got %h expected %h", i, rx0[b0+i], exp0[i]); end
            end
            for (int i = 0; i < exp1.size(); i++) begin
                checks++; if (rx1[b1+i] !== exp1[i]) begin errors++; $display("[TB] FAIL rnd_ch1_%0d: got %h expected %h", i, rx1[b1+i], exp1[i]); end
            end
        end
        checks++; if (freeCnt - bf !== n) begin errors++; $display("[TB] FAIL rnd_free_count: got %0d expected %0d", freeCnt - bf, n); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("[TB] FAIL rnd_err: got %b expected 0", o_err); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        autoFree0 = 0; autoFree1 = 0; armed0 = 0; armed1 = 0; wait0 = 0; wait1 = 0;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_independence();
        test_errors();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
